// File: rtl/tms5200_kmult.sv
// ============================================================================
// Module  : tms5200_kmult
// Brief   : 5-stage skewed radix-4 Booth digit multiplier producing K*Y for
//           the lattice filter, with arithmetic shift and output saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tms5200_kmult #(
    parameter int YW        = 14,
    parameter int OUT_SHIFT = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              in_valid,
    input  logic [YW-1:0]     yin,
    input  logic [4:0]        p1_stage,
    input  logic [4:0]        m1_stage,
    input  logic [3:0]        p2_stage,
    input  logic [4:0]        m2_stage,
    output logic [YW-1:0]     prod,
    output logic [YW+9:0]     prod_full,
    output logic              out_valid,
    output logic              sat
);

    localparam int AW = YW + 10;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (YW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    // Selects are summed rather than decoded so illegal combinations stay deterministic.
    function automatic logic signed [3:0] digit(input logic p1, input logic m1,
                                                input logic p2, input logic m2);
        return $signed({3'b000, p1}) - $signed({3'b000, m1})
             + $signed({2'b00, p2, 1'b0}) - $signed({2'b00, m2, 1'b0});
    endfunction

    function automatic logic signed [AW-1:0] sext_d(input logic signed [3:0] d);
        return {{(AW-4){d[3]}}, d};
    endfunction

    function automatic logic signed [AW-1:0] sext_y(input logic [YW-1:0] y);
        return {{(AW-YW){y[YW-1]}}, y};
    endfunction

    logic signed [3:0]    dig0, dig1, dig2, dig3, dig4;
    logic signed [AW-1:0] shifted;

    logic signed [AW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic signed [AW-1:0] acc_c_q, acc_c_d, acc_d_q, acc_d_d;
    logic [YW-1:0]        y_a_q, y_a_d, y_b_q, y_b_d, y_c_q, y_c_d;
    logic                 v_a_q, v_a_d, v_b_q, v_b_d, v_c_q, v_c_d, v_d_q, v_d_d;
    logic [YW-1:0]        prod_q, prod_d;
    logic [AW-1:0]        prod_full_q, prod_full_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sat_q, sat_d;

    always_comb begin
        dig0 = digit(p1_stage[0], m1_stage[0], 1'b0,        m2_stage[0]);
        dig1 = digit(p1_stage[1], m1_stage[1], p2_stage[0], m2_stage[1]);
        dig2 = digit(p1_stage[2], m1_stage[2], p2_stage[1], m2_stage[2]);
        dig3 = digit(p1_stage[3], m1_stage[3], p2_stage[2], m2_stage[3]);
        dig4 = digit(p1_stage[4], m1_stage[4], p2_stage[3], m2_stage[4]);

        // Each stage folds in the digit that the K stack presents on this tick.
        acc_a_d = (sext_d(dig0) + (sext_d(dig1) <<< 2)) * sext_y(yin);
        acc_b_d = acc_a_q + ((sext_d(dig2) * sext_y(y_a_q)) <<< 4);
        acc_c_d = acc_b_q + ((sext_d(dig3) * sext_y(y_b_q)) <<< 6);
        acc_d_d = acc_c_q + ((sext_d(dig4) * sext_y(y_c_q)) <<< 8);

        y_a_d = yin;
        y_b_d = y_a_q;
        y_c_d = y_b_q;
        v_a_d = in_valid;
        v_b_d = v_a_q;
        v_c_d = v_b_q;
        v_d_d = v_c_q;

        shifted     = acc_d_q >>> OUT_SHIFT;
        prod_full_d = acc_d_q;
        out_valid_d = v_d_q;
        if (shifted > SAT_MAX) begin
            prod_d = {1'b0, {(YW-1){1'b1}}};
            sat_d  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            prod_d = {1'b1, {(YW-1){1'b0}}};
            sat_d  = 1'b1;
        end else begin
            prod_d = shifted[YW-1:0];
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            acc_c_q     <= '0;
            acc_d_q     <= '0;
            y_a_q       <= '0;
            y_b_q       <= '0;
            y_c_q       <= '0;
            v_a_q       <= 1'b0;
            v_b_q       <= 1'b0;
            v_c_q       <= 1'b0;
            v_d_q       <= 1'b0;
            prod_q      <= '0;
            prod_full_q <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else if (clk_en) begin
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            acc_c_q     <= acc_c_d;
            acc_d_q     <= acc_d_d;
            y_a_q       <= y_a_d;
            y_b_q       <= y_b_d;
            y_c_q       <= y_c_d;
            v_a_q       <= v_a_d;
            v_b_q       <= v_b_d;
            v_c_q       <= v_c_d;
            v_d_q       <= v_d_d;
            prod_q      <= prod_d;
            prod_full_q <= prod_full_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign prod      = prod_q;
    assign prod_full = prod_full_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;

endmodule

`default_nettype wire
